// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared opcode, state and ALU-mode constants for the SISC controller
package sisc_pkg;

    localparam logic [3:0] OP_NOOP = 4'd0;
    localparam logic [3:0] OP_LOD  = 4'd1;
    localparam logic [3:0] OP_STR  = 4'd2;
    localparam logic [3:0] OP_SWP  = 4'd3;
    localparam logic [3:0] OP_BRA  = 4'd4;
    localparam logic [3:0] OP_BRR  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_BNR  = 4'd7;
    localparam logic [3:0] OP_ALU  = 4'd8;

    localparam int AM_IMM_DEF = 8;

    localparam logic [2:0] S_START  = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_WB2    = 3'd6;
    localparam logic [2:0] S_HALT   = 3'd7;

    typedef logic [1:0] alu_op_t;

    localparam alu_op_t ALU_REG_EXEC = 2'b00;
    localparam alu_op_t ALU_IMM_EXEC = 2'b01;
    localparam alu_op_t ALU_REG_HOLD = 2'b10;
    localparam alu_op_t ALU_IMM_HOLD = 2'b11;

    // The hold code is the exec code with the hold bit set.
    function automatic alu_op_t alu_hold(input alu_op_t exec_op);
        return exec_op | 2'b10;
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// rtl/ctrl_wait_timer.sv - memory wait-state watchdog counter
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear the count (ready seen or not in a waiting state)
//   inc      : one more wait cycle observed
//   expire   : this wait cycle would bring the count to TMO
module ctrl_wait_timer #(
    parameter int TMO   = 16,
    parameter int TMO_W = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam bit             EN   = (TMO > 0);
    localparam logic [TMO_W-1:0] LAST = (TMO > 0) ? TMO_W'(TMO - 1) : '0;

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !EN) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    // Fires on the wait cycle that would make the count equal TMO.
    assign expire = EN && inc && !clr && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sisc_ctrl_hs.sv
// rtl/sisc_ctrl_hs.sv - multi-cycle SISC control FSM with memory req/ready handshakes
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   opcode, mm, stat    : IR opcode, IR mode/condition field, status flags
//   imem_rdy, dmem_rdy  : memory ready inputs
//   imem_req, dmem_req, dmem_we : memory request outputs
//   ir_load, pc_rst, pc_write, pc_sel, br_sel : IR / PC controls
//   rf_we, wb_sel, rb_sel, swp_ph, alu_op     : datapath controls
//   halted, bus_err     : core halted, sticky watchdog error
module sisc_ctrl_hs
    import sisc_pkg::*;
#(
    parameter int OPC_W  = 4,
    parameter int CC_W   = 4,
    parameter int AM_IMM = AM_IMM_DEF,
    parameter int TMO    = 16,
    parameter int TMO_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic [CC_W-1:0]  mm,
    input  logic [CC_W-1:0]  stat,
    input  logic             imem_rdy,
    input  logic             dmem_rdy,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_load,
    output logic             pc_rst,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             br_sel,
    output logic             rf_we,
    output logic             wb_sel,
    output logic             rb_sel,
    output logic             swp_ph,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic             bus_err
);

    logic [2:0] state_q, state_d;
    logic       bus_err_q, bus_err_d;

    logic is_lod, is_str, is_swp, is_alu, is_noop, is_hlt;
    logic is_bra, is_brr, is_bne, is_bnr, is_br;
    logic hit, taken, imm_mode, mem_op;
    logic wait_st, wt_clr, wt_inc, expire;

    assign is_noop = (opcode == OPC_W'(OP_NOOP));
    assign is_lod  = (opcode == OPC_W'(OP_LOD));
    assign is_str  = (opcode == OPC_W'(OP_STR));
    assign is_swp  = (opcode == OPC_W'(OP_SWP));
    assign is_bra  = (opcode == OPC_W'(OP_BRA));
    assign is_brr  = (opcode == OPC_W'(OP_BRR));
    assign is_bne  = (opcode == OPC_W'(OP_BNE));
    assign is_bnr  = (opcode == OPC_W'(OP_BNR));
    assign is_alu  = (opcode == OPC_W'(OP_ALU));
    assign is_hlt  = &opcode;
    assign is_br   = is_bra | is_brr | is_bne | is_bnr;
    assign mem_op  = is_lod | is_str;

    assign hit      = |(mm & stat);
    assign taken    = (is_bra | is_brr) ? hit : !hit;
    assign imm_mode = (is_alu && (mm == CC_W'(AM_IMM))) || mem_op;

    // Only FETCH and a LOD/STR in MEM actually wait on a memory.
    assign wait_st = (state_q == S_FETCH) || ((state_q == S_MEM) && mem_op);
    assign wt_inc  = wait_st && !((state_q == S_FETCH) ? imem_rdy : dmem_rdy);
    assign wt_clr  = !wt_inc;

    ctrl_wait_timer #(
        .TMO   (TMO),
        .TMO_W (TMO_W)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (wt_clr),
        .inc    (wt_inc),
        .expire (expire)
    );

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_load  = 1'b0;
        pc_rst   = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        rb_sel   = 1'b0;
        swp_ph   = 1'b0;
        alu_op   = ALU_REG_HOLD;
        halted   = 1'b0;
        case (state_q)
            S_START: begin
                pc_rst  = 1'b1;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_rdy) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (expire) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                if (is_br) begin
                    if (taken) begin
                        pc_write = 1'b1;
                        pc_sel   = 1'b1;
                        br_sel   = is_brr | is_bnr;
                    end
                    state_d = S_FETCH;
                end else if (is_noop) begin
                    state_d = S_FETCH;
                end else if (is_hlt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op  = imm_mode ? ALU_IMM_EXEC : ALU_REG_EXEC;
                rb_sel  = is_str;
                state_d = S_MEM;
            end
            S_MEM: begin
                alu_op = alu_hold(imm_mode ? ALU_IMM_EXEC : ALU_REG_EXEC);
                rb_sel = is_str;
                if (mem_op) begin
                    dmem_req = 1'b1;
                    dmem_we  = is_str;
                    if (dmem_rdy) begin
                        state_d = is_str ? S_FETCH : S_WB;
                    end else if (expire) begin
                        state_d = S_HALT;
                    end
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                rf_we   = is_alu | is_lod | is_swp;
                wb_sel  = is_lod;
                state_d = is_swp ? S_WB2 : S_FETCH;
            end
            S_WB2: begin
                rf_we   = 1'b1;
                swp_ph  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_START;
            end
        endcase
    end

    assign bus_err_d = bus_err_q | expire;
    assign bus_err   = bus_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_START;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_sisc_ctrl_hs.sv
// tb/tb_sisc_ctrl_hs.sv - directed self-checking bench for sisc_ctrl_hs
module tb_sisc_ctrl_hs;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode, mm, stat;
    logic       imem_rdy, dmem_rdy;
    logic       imem_req, dmem_req, dmem_we, ir_load, pc_rst, pc_write, pc_sel, br_sel;
    logic       rf_we, wb_sel, rb_sel, swp_ph, halted, bus_err;
    logic [1:0] alu_op;

    int n_tests = 0;
    int n_fail  = 0;

    sisc_ctrl_hs #(
        .OPC_W  (4),
        .CC_W   (4),
        .AM_IMM (8),
        .TMO    (4),
        .TMO_W  (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .mm       (mm),
        .stat     (stat),
        .imem_rdy (imem_rdy),
        .dmem_rdy (dmem_rdy),
        .imem_req (imem_req),
        .dmem_req (dmem_req),
        .dmem_we  (dmem_we),
        .ir_load  (ir_load),
        .pc_rst   (pc_rst),
        .pc_write (pc_write),
        .pc_sel   (pc_sel),
        .br_sel   (br_sel),
        .rf_we    (rf_we),
        .wb_sel   (wb_sel),
        .rb_sel   (rb_sel),
        .swp_ph   (swp_ph),
        .alu_op   (alu_op),
        .halted   (halted),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Branch table: opcode, stat (mm fixed at 0010), expected pc_write, br_sel
    logic [3:0] br_op   [6] = '{4'd5, 4'd6, 4'd7, 4'd4, 4'd4, 4'd0};
    logic [3:0] br_stat [6] = '{4'd2, 4'd2, 4'd4, 4'd4, 4'd2, 4'd2};
    logic       br_pw   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       br_bs   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int nreq;
        rst = 1'b1; opcode = '0; mm = '0; stat = '0; imem_rdy = 1'b0; dmem_rdy = 1'b0;
        tick(); tick();
        check_eq("rst_pc_rst",   32'(pc_rst),   1);
        check_eq("rst_alu_op",   32'(alu_op),   2);
        check_eq("rst_imem_req", 32'(imem_req), 0);
        check_eq("rst_halted",   32'(halted),   0);
        check_eq("rst_bus_err",  32'(bus_err),  0);
        rst = 1'b0;
        #1;
        check_eq("start_hold", 32'(pc_rst), 1);
        tick();
        check_eq("fetch_entry_req", 32'(imem_req), 1);
        check_eq("fetch_entry_pcr", 32'(pc_rst),   0);

        // ALU immediate, zero waits: FETCH DECODE EXEC MEM WB
        opcode = 4'd8; mm = 4'd8; imem_rdy = 1'b1; dmem_rdy = 1'b1;
        #1;
        check_eq("alu_f_ir_load",  32'(ir_load),  1);
        check_eq("alu_f_pc_write", 32'(pc_write), 1);
        check_eq("alu_f_pc_sel",   32'(pc_sel),   0);
        tick();
        check_eq("alu_d_pc_write", 32'(pc_write), 0);
        tick();
        check_eq("alu_e_op", 32'(alu_op), 1);
        tick();
        check_eq("alu_m_op",   32'(alu_op),   3);
        check_eq("alu_m_dreq", 32'(dmem_req), 0);
        tick();
        check_eq("alu_wb_rf_we",  32'(rf_we),  1);
        check_eq("alu_wb_wb_sel", 32'(wb_sel), 0);
        tick();
        check_eq("alu_lat5", 32'(imem_req), 1);

        // ALU register mode
        mm = 4'd0;
        tick(); tick();
        check_eq("alureg_e_op", 32'(alu_op), 0);
        tick();
        check_eq("alureg_m_op", 32'(alu_op), 2);
        tick(); tick();
        check_eq("alureg_lat5", 32'(imem_req), 1);

        // Branches and NOOP, mm = 0010
        mm = 4'd2;
        for (int i = 0; i < 6; i++) begin
            opcode = br_op[i]; stat = br_stat[i];
            tick();
            check_eq($sformatf("br%0d_pc_write", i), 32'(pc_write), 32'(br_pw[i]));
            check_eq($sformatf("br%0d_pc_sel", i),   32'(pc_sel),   32'(br_pw[i]));
            check_eq($sformatf("br%0d_br_sel", i),   32'(br_sel),   32'(br_bs[i]));
            tick();
            check_eq($sformatf("br%0d_lat2", i), 32'(imem_req), 1);
        end

        // LOD with dmem_rdy delayed 3 cycles
        opcode = 4'd1; mm = 4'd0; stat = 4'd0; dmem_rdy = 1'b0;
        tick(); tick();
        check_eq("lod_e_op", 32'(alu_op), 1);
        tick();
        nreq = 0;
        check_eq("lod_m_we", 32'(dmem_we), 0);
        check_eq("lod_m_op", 32'(alu_op),  3);
        for (int i = 0; i < 3; i++) begin
            if (dmem_req) nreq++;
            tick();
        end
        dmem_rdy = 1'b1;
        #1;
        if (dmem_req) nreq++;
        check_eq("lod_req_cycles", 32'(nreq), 4);
        tick();
        check_eq("lod_wb_rf_we",  32'(rf_we),    1);
        check_eq("lod_wb_wb_sel", 32'(wb_sel),   1);
        check_eq("lod_wb_dreq",   32'(dmem_req), 0);
        check_eq("lod_wb_err",    32'(bus_err),  0);
        tick();
        check_eq("lod_lat8", 32'(imem_req), 1);

        // STR, zero waits
        opcode = 4'd2;
        tick(); tick();
        check_eq("str_e_op",     32'(alu_op), 1);
        check_eq("str_e_rb_sel", 32'(rb_sel), 1);
        tick();
        check_eq("str_m_dreq",   32'(dmem_req), 1);
        check_eq("str_m_we",     32'(dmem_we),  1);
        check_eq("str_m_rb_sel", 32'(rb_sel),   1);
        check_eq("str_m_op",     32'(alu_op),   3);
        nreq = 0;
        tick();
        while (imem_req !== 1'b1 && nreq < 8) begin
            tick();
            nreq++;
        end
        check_eq("str_back_fetch", 32'(imem_req), 1);

        // SWP
        opcode = 4'd3;
        tick(); tick();
        check_eq("swp_e_op", 32'(alu_op), 0);
        tick();
        check_eq("swp_m_op",   32'(alu_op),   2);
        check_eq("swp_m_dreq", 32'(dmem_req), 0);
        tick();
        check_eq("swp_wb_rf_we",  32'(rf_we),  1);
        check_eq("swp_wb_swp_ph", 32'(swp_ph), 0);
        tick();
        check_eq("swp_wb2_rf_we",  32'(rf_we),  1);
        check_eq("swp_wb2_swp_ph", 32'(swp_ph), 1);
        tick();
        check_eq("swp_lat6", 32'(imem_req), 1);

        // Unassigned opcode passes through with no writes
        opcode = 4'd9;
        tick(); tick(); tick(); tick();
        check_eq("op9_wb_rf_we", 32'(rf_we), 0);
        tick();
        check_eq("op9_lat5", 32'(imem_req), 1);

        // FETCH with 3 wait cycles; ready on the fourth wins over the watchdog
        opcode = 4'd0; imem_rdy = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("fw%0d_ir_load", i), 32'(ir_load), 0);
            tick();
        end
        imem_rdy = 1'b1;
        #1;
        check_eq("fw_ir_load", 32'(ir_load), 1);
        tick();
        check_eq("fw_no_halt", 32'(halted),  0);
        check_eq("fw_no_err",  32'(bus_err), 0);
        tick();
        check_eq("fw_fetch", 32'(imem_req), 1);

        // Reset held 3 cycles in the middle of a LOD memory wait
        opcode = 4'd1; dmem_rdy = 1'b0;
        tick(); tick(); tick();
        check_eq("rstmem_dreq_pre", 32'(dmem_req), 1);
        rst = 1'b1;
        tick();
        check_eq("rstmem_dreq",   32'(dmem_req), 0);
        check_eq("rstmem_pc_rst", 32'(pc_rst),   1);
        tick(); tick();
        rst = 1'b0;
        #1;
        check_eq("rstmem_start", 32'(pc_rst), 1);
        tick();
        check_eq("rstmem_fetch", 32'(imem_req), 1);

        // Watchdog: imem_rdy stuck low, TMO = 4
        imem_rdy = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("tmo%0d_req", i), 32'(imem_req), 1);
            check_eq($sformatf("tmo%0d_halted", i), 32'(halted), 0);
            tick();
        end
        check_eq("tmo_halted",  32'(halted),   1);
        check_eq("tmo_bus_err", 32'(bus_err),  1);
        check_eq("tmo_no_req",  32'(imem_req), 0);
        imem_rdy = 1'b1;
        tick(); tick(); tick();
        check_eq("tmo_halt_hold", 32'(halted),  1);
        check_eq("tmo_err_hold",  32'(bus_err), 1);
        rst = 1'b1;
        tick();
        check_eq("tmo_rst_err",    32'(bus_err), 0);
        check_eq("tmo_rst_halted", 32'(halted),  0);
        check_eq("tmo_rst_pc_rst", 32'(pc_rst),  1);
        rst = 1'b0;
        tick();
        check_eq("tmo_rst_fetch", 32'(imem_req), 1);

        // HLT
        opcode = 4'd15;
        tick(); tick();
        check_eq("hlt_halted", 32'(halted), 1);
        for (int i = 0; i < 10; i++) tick();
        check_eq("hlt_hold",    32'(halted),   1);
        check_eq("hlt_no_req",  32'(imem_req), 0);
        check_eq("hlt_no_err",  32'(bus_err),  0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
